// File: rtl/hdmidatadecoder_if.sv
// ---------------------------------------------------------------------------
// hdmidatadecoder_if : data-island bus between TERC4 front end and decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hdmidatadecoder_if;
    logic        i_data;
    logic [3:0]  i_d0;
    logic [3:0]  i_d1;
    logic [3:0]  i_d2;

    logic        o_hSync;
    logic        o_vSync;
    logic [23:0] o_hdr;
    logic        o_hdr_ok;
    logic [55:0] o_sub0;
    logic [55:0] o_sub1;
    logic [55:0] o_sub2;
    logic [55:0] o_sub3;
    logic [3:0]  o_sub_ok;
    logic        o_pkt_valid;
    logic        o_sync_err;
    logic [15:0] o_cts;
    logic [15:0] o_n;
    logic        o_acr_valid;
    logic [15:0] o_audioL;
    logic [15:0] o_audioR;
    logic        o_audio_valid;

    modport master (
        output i_data, i_d0, i_d1, i_d2,
        input  o_hSync, o_vSync, o_hdr, o_hdr_ok, o_sub0, o_sub1, o_sub2, o_sub3,
               o_sub_ok, o_pkt_valid, o_sync_err, o_cts, o_n, o_acr_valid,
               o_audioL, o_audioR, o_audio_valid
    );

    modport slave (
        input  i_data, i_d0, i_d1, i_d2,
        output o_hSync, o_vSync, o_hdr, o_hdr_ok, o_sub0, o_sub1, o_sub2, o_sub3,
               o_sub_ok, o_pkt_valid, o_sync_err, o_cts, o_n, o_acr_valid,
               o_audioL, o_audioR, o_audio_valid
    );
endinterface

`default_nettype wire

// File: rtl/hdmidatadecoder.sv
// ---------------------------------------------------------------------------
// hdmidatadecoder : HDMI data-island packet capture, BCH check, ACR and audio
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hdmidatadecoder (
    input  wire logic          i_pixclk,
    input  wire logic          i_reset,
    hdmidatadecoder_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EMIT0 = 3'd1,
        ST_EMIT1 = 3'd2,
        ST_EMIT2 = 3'd3,
        ST_EMIT3 = 3'd4
    } state_t;

    localparam logic [7:0] C_BCH_POLY  = 8'hC1;
    localparam logic [7:0] C_TYPE_ACR  = 8'h01;
    localparam logic [7:0] C_TYPE_AUD  = 8'h02;

    function automatic logic [7:0] bch8(input logic [55:0] data, input int nbits);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 56; i++) begin
            if (i < nbits) begin
                r = {r[6:0], 1'b0} ^ ((r[7] ^ data[i]) ? C_BCH_POLY : 8'h00);
            end
        end
        return r;
    endfunction

    // First received parity bit is the MSB of the comparison byte.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) begin
            o[i] = v[7-i];
        end
        return o;
    endfunction

    logic [4:0]  cnt_q;
    logic        first_q;
    logic [30:0] hdr_sr_q;
    logic [61:0] sub_sr_q [4];

    logic [23:0] hdr_q;
    logic        hdr_ok_q;
    logic [55:0] sub_q [4];
    logic [3:0]  sub_ok_q;
    logic        pkt_valid_q;
    logic        sync_err_q;
    logic [15:0] cts_q;
    logic [15:0] n_q;
    logic        acr_valid_q;
    logic        hsync_q;
    logic        vsync_q;

    state_t      state_q;
    logic        aud_valid_q;
    logic [15:0] aud_l_q;
    logic [15:0] aud_r_q;

    logic [31:0] w_hdr_full;
    logic [63:0] w_sub_full [4];
    logic        w_hdr_ok;
    logic [3:0]  w_sub_ok;
    logic        w_emit_go;
    logic [1:0]  w_emit_idx;
    logic [3:0]  w_layout;
    logic        w_emit_sample;

    // Shift registers fill from the top so that bit n lands at index n on cnt=31.
    always_comb begin
        w_hdr_full = {bus.i_d0[2], hdr_sr_q};
        w_hdr_ok   = (rev8(w_hdr_full[31:24]) == bch8({32'd0, w_hdr_full[23:0]}, 24));
        for (int k = 0; k < 4; k++) begin
            w_sub_full[k] = {bus.i_d2[k], bus.i_d1[k], sub_sr_q[k]};
            w_sub_ok[k]   = (rev8(w_sub_full[k][63:56]) == bch8(w_sub_full[k][55:0], 56));
        end
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q       <= 5'd0;
            first_q     <= 1'b1;
            hdr_sr_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                sub_sr_q[k] <= '0;
                sub_q[k]    <= '0;
            end
            hdr_q       <= '0;
            hdr_ok_q    <= 1'b0;
            sub_ok_q    <= 4'd0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            cts_q       <= '0;
            n_q         <= '0;
            acr_valid_q <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            pkt_valid_q <= 1'b0;
            acr_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (bus.i_data) begin
                cnt_q      <= cnt_q + 5'd1;
                first_q    <= 1'b0;
                hsync_q    <= bus.i_d0[0];
                vsync_q    <= bus.i_d0[1];
                // Framing bit is low only on the very first cycle of an island.
                sync_err_q <= (bus.i_d0[3] != ~first_q);
                hdr_sr_q   <= w_hdr_full[31:1];
                for (int k = 0; k < 4; k++) begin
                    sub_sr_q[k] <= w_sub_full[k][63:2];
                end
                if (cnt_q == 5'd31) begin
                    pkt_valid_q <= 1'b1;
                    hdr_q       <= w_hdr_full[23:0];
                    hdr_ok_q    <= w_hdr_ok;
                    sub_ok_q    <= w_sub_ok;
                    for (int k = 0; k < 4; k++) begin
                        sub_q[k] <= w_sub_full[k][55:0];
                    end
                    if (w_hdr_full[7:0] == C_TYPE_ACR && w_hdr_ok && w_sub_ok[0]) begin
                        acr_valid_q <= 1'b1;
                        cts_q       <= {w_sub_full[0][23:16], w_sub_full[0][31:24]};
                        n_q         <= {w_sub_full[0][47:40], w_sub_full[0][55:48]};
                    end
                end
            end else begin
                cnt_q   <= 5'd0;
                first_q <= 1'b1;
            end
        end
    end

    // Which subpacket (if any) is emitted on the edge that enters the next state.
    always_comb begin
        w_emit_go  = 1'b1;
        w_emit_idx = 2'd0;
        case (state_q)
            ST_IDLE:  w_emit_go  = pkt_valid_q && (hdr_q[7:0] == C_TYPE_AUD) && hdr_ok_q;
            ST_EMIT0: w_emit_idx = 2'd1;
            ST_EMIT1: w_emit_idx = 2'd2;
            ST_EMIT2: w_emit_idx = 2'd3;
            default:  w_emit_go  = 1'b0;
        endcase
        w_layout      = hdr_q[11:8];
        w_emit_sample = w_emit_go && w_layout[w_emit_idx] && sub_ok_q[w_emit_idx];
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            aud_valid_q <= 1'b0;
            aud_l_q     <= '0;
            aud_r_q     <= '0;
        end else begin
            aud_valid_q <= w_emit_sample;
            if (w_emit_sample) begin
                aud_l_q <= sub_q[w_emit_idx][23:8];
                aud_r_q <= sub_q[w_emit_idx][47:32];
            end
            case (state_q)
                ST_IDLE:  if (w_emit_go) state_q <= ST_EMIT0;
                ST_EMIT0: state_q <= ST_EMIT1;
                ST_EMIT1: state_q <= ST_EMIT2;
                ST_EMIT2: state_q <= ST_EMIT3;
                ST_EMIT3: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_hSync       = hsync_q;
    assign bus.o_vSync       = vsync_q;
    assign bus.o_hdr         = hdr_q;
    assign bus.o_hdr_ok      = hdr_ok_q;
    assign bus.o_sub0        = sub_q[0];
    assign bus.o_sub1        = sub_q[1];
    assign bus.o_sub2        = sub_q[2];
    assign bus.o_sub3        = sub_q[3];
    assign bus.o_sub_ok      = sub_ok_q;
    assign bus.o_pkt_valid   = pkt_valid_q;
    assign bus.o_sync_err    = sync_err_q;
    assign bus.o_cts         = cts_q;
    assign bus.o_n           = n_q;
    assign bus.o_acr_valid   = acr_valid_q;
    assign bus.o_audioL      = aud_l_q;
    assign bus.o_audioR      = aud_r_q;
    assign bus.o_audio_valid = aud_valid_q;

endmodule

`default_nettype wire
